reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised multi-port register file. Replaces the discrete register, 4:1 read mux and 1:4 store demux arrangement in the processor datapath.
- Provides two combinational read ports, one synchronous write port, an optional hardwired-zero R0, and optional write-to-read bypass.
- Includes a per-register busy scoreboard so the control unit can stall reads of registers with an outstanding write.

Parameters:
- WIDTH, 16, data width in bits of every register.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers (default 4).
- ZERO_R0, 0, if 1, R0 always reads 0, and writes or reservations to R0 are ignored.
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- we, input, 1, write enable.
- waddr, input, ADDR_W, write address.
- wdata, input, WIDTH, write data.
- raddr_a, input, ADDR_W, read port A address.
- rdata_a, output, WIDTH, read port A data (combinational).
- raddr_b, input, ADDR_W, read port B address.
- rdata_b, output, WIDTH, read port B data (combinational).
- rsv, input, 1, reserve: mark register rsv_addr busy (pending write).
- rsv_addr, input, ADDR_W, register to reserve.
- busy_a, output, 1, register at raddr_a has a pending write.
- busy_b, output, 1, register at raddr_b has a pending write.
- busy_vec, output, DEPTH, raw scoreboard state, bit i = register i busy.

Behaviour:
- Reset:
  - rst=1 asynchronously clears all registers to 0 and all busy bits to 0.
  - While rst is high: rdata_a/b=0, busy_a/b=0, busy_vec=0; we and rsv are ignored.
  - Reset asserted mid-operation discards all pending reservations.
- Write:
  - On a rising edge with we=1, reg[waddr] <= wdata.
  - Takes effect the cycle after the edge without bypass.
- Read:
  - rdata_x = reg[raddr_x], combinational, zero-latency.
  - Both ports may read the same address.
- Bypass (BYPASS=1): if we=1 and waddr==raddr_x, rdata_x = wdata in the same cycle. Applies to each port independently.
- ZERO_R0=1:
  - reg[0] never changes; reads of address 0 return 0 regardless of bypass.
  - busy[0] is never set.
- Scoreboard, evaluated on each rising edge:
  - rsv=1 sets busy[rsv_addr].
  - we=1 clears busy[waddr].
  - If rsv and we target the same address in the same cycle, set wins: a new producer has been issued and the data write still occurs.
  - If rsv and we target different addresses, both actions occur.
  - Writes to a non-busy register are legal and leave busy at 0.
  - Reserving an already-busy register leaves it busy; there is no counting, so a single write clears it.
- Busy outputs:
  - busy_x = busy[raddr_x].
  - With BYPASS=1, busy_x is forced to 0 when we=1 and waddr==raddr_x, because the data is available through bypass this cycle.
  - With BYPASS=0, busy_x is not masked by a same-cycle write.
  - busy_vec is always the raw registered state, never masked.
- Address range: all DEPTH addresses are valid, so there is no out-of-range condition.

Test Plan:
- Reset: after rst pulse, read all 4 addresses on both ports -> rdata=0x0000, busy_vec=4'b0000; assert rst mid-run with busy_vec=4'b0110 -> busy_vec=0 and all regs 0 immediately, without waiting for a clock edge.
- Write/read: write 0x1234 to R2, 0xBEEF to R3; next cycle raddr_a=2, raddr_b=3 -> rdata_a=0x1234, rdata_b=0xBEEF; raddr_a=raddr_b=3 -> both 0xBEEF.
- Bypass: BYPASS=1, we=1, waddr=1, wdata=0xA5A5, raddr_a=1 in the same cycle -> rdata_a=0xA5A5 before the edge; BYPASS=0 -> old value, 0xA5A5 only after the edge.
- Scoreboard: rsv R1 -> busy_vec=4'b0010 and busy_a=1 for raddr_a=1; write R1 with BYPASS=1 -> busy_a=0 during the write cycle and busy_vec=0 after the edge; same-edge rsv=1 and we=1 both on R2 -> R2 updated, busy_vec[2]=1.
- ZERO_R0=1: write 0xFFFF to R0 and rsv R0 -> rdata for address 0 stays 0x0000, busy_vec[0]=0, and a bypass read of address 0 also returns 0.
- Width/depth: WIDTH=32, ADDR_W=3: write 0xDEADBEEF to R7, then read it back -> 0xDEADBEEF; rsv R5 -> busy_vec=8'h20.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_sb : 2R/1W register file with write bypass and busy board   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module reg_file_sb #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 2,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [ADDR_W-1:0]      raddr_a,
   output logic [WIDTH-1:0]       rdata_a,
   input  logic [ADDR_W-1:0]      raddr_b,
   output logic [WIDTH-1:0]       rdata_b,
   input  logic                   rsv,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic                   busy_a,
   output logic                   busy_b,
   output logic [(2**ADDR_W)-1:0] busy_vec
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [WIDTH-1:0]   regs_q [c_DEPTH];
   logic [WIDTH-1:0]   regs_d [c_DEPTH];
   logic [c_DEPTH-1:0] busy_q;
   logic [c_DEPTH-1:0] busy_d;
   logic               w_wr_r0;
   logic               w_byp_a;
   logic               w_byp_b;

   assign w_wr_r0 = (ZERO_R0 != 0) && (waddr == '0);

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (we && !w_wr_r0) begin
         regs_d[waddr] = wdata;
      end
      if (we) begin
         busy_d[waddr] = 1'b0;
      end
      // Applied after the clear so a fresh reservation wins on the same register.
      if (rsv) begin
         busy_d[rsv_addr] = 1'b1;
      end
      if (ZERO_R0 != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Forwarding is gated by rst so outputs stay zero while reset is held.
   assign w_byp_a = (BYPASS != 0) && we && !rst && (waddr == raddr_a);
   assign w_byp_b = (BYPASS != 0) && we && !rst && (waddr == raddr_b);

   always_comb begin
      rdata_a = regs_q[raddr_a];
      if (w_byp_a) begin
         rdata_a = wdata;
      end
      if ((ZERO_R0 != 0) && (raddr_a == '0)) begin
         rdata_a = '0;
      end
   end

   always_comb begin
      rdata_b = regs_q[raddr_b];
      if (w_byp_b) begin
         rdata_b = wdata;
      end
      if ((ZERO_R0 != 0) && (raddr_b == '0)) begin
         rdata_b = '0;
      end
   end

   assign busy_a   = busy_q[raddr_a] && !w_byp_a;
   assign busy_b   = busy_q[raddr_b] && !w_byp_b;
   assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file_sb : directed scoreboard bench for reg_file_sb           |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_reg_file_sb;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   // d0: defaults (bypass on); d1: bypass off; d2: 32-bit, 8 deep, hardwired R0
   logic        we0, rsv0, busy_a0, busy_b0;
   logic [1:0]  waddr0, raddr_a0, raddr_b0, rsv_addr0;
   logic [15:0] wdata0, rdata_a0, rdata_b0;
   logic [3:0]  busy_vec0;

   logic        we1, rsv1, busy_a1, busy_b1;
   logic [1:0]  waddr1, raddr_a1, raddr_b1, rsv_addr1;
   logic [15:0] wdata1, rdata_a1, rdata_b1;
   logic [3:0]  busy_vec1;

   logic        we2, rsv2, busy_a2, busy_b2;
   logic [2:0]  waddr2, raddr_a2, raddr_b2, rsv_addr2;
   logic [31:0] wdata2, rdata_a2, rdata_b2;
   logic [7:0]  busy_vec2;

   reg_file_sb #(.WIDTH(16), .ADDR_W(2), .ZERO_R0(0), .BYPASS(1)) u_d0 (
      .clk(clk), .rst(rst), .we(we0), .waddr(waddr0), .wdata(wdata0),
      .raddr_a(raddr_a0), .rdata_a(rdata_a0), .raddr_b(raddr_b0), .rdata_b(rdata_b0),
      .rsv(rsv0), .rsv_addr(rsv_addr0), .busy_a(busy_a0), .busy_b(busy_b0),
      .busy_vec(busy_vec0));

   reg_file_sb #(.WIDTH(16), .ADDR_W(2), .ZERO_R0(0), .BYPASS(0)) u_d1 (
      .clk(clk), .rst(rst), .we(we1), .waddr(waddr1), .wdata(wdata1),
      .raddr_a(raddr_a1), .rdata_a(rdata_a1), .raddr_b(raddr_b1), .rdata_b(rdata_b1),
      .rsv(rsv1), .rsv_addr(rsv_addr1), .busy_a(busy_a1), .busy_b(busy_b1),
      .busy_vec(busy_vec1));

   reg_file_sb #(.WIDTH(32), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) u_d2 (
      .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
      .raddr_a(raddr_a2), .rdata_a(rdata_a2), .raddr_b(raddr_b2), .rdata_b(rdata_b2),
      .rsv(rsv2), .rsv_addr(rsv_addr2), .busy_a(busy_a2), .busy_b(busy_b2),
      .busy_vec(busy_vec2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      we0 = 0; rsv0 = 0; waddr0 = 0; wdata0 = 0; raddr_a0 = 0; raddr_b0 = 0; rsv_addr0 = 0;
      we1 = 0; rsv1 = 0; waddr1 = 0; wdata1 = 0; raddr_a1 = 0; raddr_b1 = 0; rsv_addr1 = 0;
      we2 = 0; rsv2 = 0; waddr2 = 0; wdata2 = 0; raddr_a2 = 0; raddr_b2 = 0; rsv_addr2 = 0;

      // Writes and reservations attempted during reset must have no effect
      @(negedge clk);
      we0 = 1; waddr0 = 1; wdata0 = 16'hFFFF; raddr_a0 = 1; rsv0 = 1; rsv_addr0 = 1;
      push("rst_byp_rdata_a", 64'h0);
      push("rst_busy_a", 64'h0);
      #1; chk(64'(rdata_a0)); chk(64'(busy_a0));
      @(negedge clk);
      push("rst_held_vec", 64'h0);
      #1; chk(64'(busy_vec0));
      we0 = 0; rsv0 = 0;
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 4; i++) begin
         raddr_a0 = 2'(i); raddr_b0 = 2'(3 - i);
         push("reset_rdata_a", 64'h0);
         push("reset_rdata_b", 64'h0);
         push("reset_busy_vec", 64'h0);
         #1; chk(64'(rdata_a0)); chk(64'(rdata_b0)); chk(64'(busy_vec0));
      end

      // Basic write then read back on both ports
      @(negedge clk);
      we0 = 1; waddr0 = 2; wdata0 = 16'h1234;
      @(negedge clk);
      waddr0 = 3; wdata0 = 16'hBEEF;
      @(negedge clk);
      we0 = 0; raddr_a0 = 2; raddr_b0 = 3;
      push("wr_rdata_a_r2", 64'h1234);
      push("wr_rdata_b_r3", 64'hBEEF);
      #1; chk(64'(rdata_a0)); chk(64'(rdata_b0));
      raddr_a0 = 3;
      push("same_addr_a", 64'hBEEF);
      push("same_addr_b", 64'hBEEF);
      #1; chk(64'(rdata_a0)); chk(64'(rdata_b0));

      // Bypass on d0 versus no bypass on d1
      @(negedge clk);
      we0 = 1; waddr0 = 1; wdata0 = 16'hA5A5; raddr_a0 = 1;
      we1 = 1; waddr1 = 1; wdata1 = 16'hA5A5; raddr_a1 = 1;
      push("byp_on_rdata_a", 64'hA5A5);
      push("byp_off_rdata_a_old", 64'h0);
      #1; chk(64'(rdata_a0)); chk(64'(rdata_a1));
      @(negedge clk);
      we0 = 0; we1 = 0;
      push("byp_off_rdata_a_new", 64'hA5A5);
      #1; chk(64'(rdata_a1));

      // Reserve R1 on both, then write it
      @(negedge clk);
      rsv0 = 1; rsv_addr0 = 1; rsv1 = 1; rsv_addr1 = 1;
      push("rsv_pre_edge_vec", 64'h0);
      #1; chk(64'(busy_vec0));
      @(negedge clk);
      rsv0 = 0; rsv1 = 0;
      push("rsv_r1_vec", 64'h2);
      push("rsv_r1_busy_a", 64'h1);
      #1; chk(64'(busy_vec0)); chk(64'(busy_a0));
      @(negedge clk);
      we0 = 1; waddr0 = 1; wdata0 = 16'h5555;
      we1 = 1; waddr1 = 1; wdata1 = 16'h5555;
      push("wr_busy_a_masked", 64'h0);
      push("wr_rdata_a_byp", 64'h5555);
      push("wr_vec_raw", 64'h2);
      push("nobyp_busy_a", 64'h1);
      push("nobyp_rdata_a", 64'hA5A5);
      #1; chk(64'(busy_a0)); chk(64'(rdata_a0)); chk(64'(busy_vec0));
      chk(64'(busy_a1)); chk(64'(rdata_a1));
      @(negedge clk);
      we0 = 0; we1 = 0;
      push("wr_clear_vec", 64'h0);
      push("nobyp_clear_vec", 64'h0);
      #1; chk(64'(busy_vec0)); chk(64'(busy_vec1));

      // Same-address reserve and write: set wins, data still written
      @(negedge clk);
      rsv0 = 1; rsv_addr0 = 2; we0 = 1; waddr0 = 2; wdata0 = 16'h7777; raddr_a0 = 2;
      @(negedge clk);
      rsv0 = 0; we0 = 0;
      push("set_wins_rdata", 64'h7777);
      push("set_wins_vec", 64'h4);
      #1; chk(64'(rdata_a0)); chk(64'(busy_vec0));
      // Different addresses: reserve R1 and write R2 in one edge
      @(negedge clk);
      rsv0 = 1; rsv_addr0 = 1; we0 = 1; waddr0 = 2; wdata0 = 16'h8888;
      @(negedge clk);
      rsv0 = 1; rsv_addr0 = 2; we0 = 0;
      push("diff_addr_vec", 64'h2);
      #1; chk(64'(busy_vec0));
      @(negedge clk);
      rsv0 = 0;
      raddr_a0 = 2; raddr_b0 = 3;
      push("pre_reset_vec", 64'h6);
      push("pre_reset_rdata_a", 64'h8888);
      #1; chk(64'(busy_vec0)); chk(64'(rdata_a0));

      // Asynchronous reset between clock edges
      #1; rst = 1;
      #1;
      push("async_rst_vec", 64'h0);
      push("async_rst_rdata_a", 64'h0);
      push("async_rst_rdata_b", 64'h0);
      chk(64'(busy_vec0)); chk(64'(rdata_a0)); chk(64'(rdata_b0));
      @(negedge clk);
      rst = 0;

      // Hardwired R0 on d2
      @(negedge clk);
      we2 = 1; waddr2 = 0; wdata2 = 32'hFFFF_FFFF; rsv2 = 1; rsv_addr2 = 0; raddr_a2 = 0;
      push("zr0_byp_rdata", 64'h0);
      push("zr0_busy_a", 64'h0);
      #1; chk(64'(rdata_a2)); chk(64'(busy_a2));
      @(negedge clk);
      we2 = 0; rsv2 = 0;
      push("zr0_rdata", 64'h0);
      push("zr0_vec", 64'h0);
      #1; chk(64'(rdata_a2)); chk(64'(busy_vec2));

      // Wide/deep configuration
      @(negedge clk);
      we2 = 1; waddr2 = 7; wdata2 = 32'hDEAD_BEEF;
      @(negedge clk);
      we2 = 0; rsv2 = 1; rsv_addr2 = 5; raddr_a2 = 7; raddr_b2 = 5;
      push("wide_rdata_r7", 64'hDEAD_BEEF);
      #1; chk(64'(rdata_a2));
      @(negedge clk);
      rsv2 = 0;
      push("wide_vec_r5", 64'h20);
      push("wide_busy_b", 64'h1);
      #1; chk(64'(busy_vec2)); chk(64'(busy_b2));

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
